adder_cla_pipe: RTL
===================

Name: adder_cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Successor to the team's fixed 8-bit combinational CLA. Adds configurable width, segmented pipelining, subtract mode, signed-overflow output and a valid/ready handshake with backpressure.
- Sits in datapath pipelines wherever a wide add must close timing at high clock rates.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be an integer multiple of SEG_W.
- SEG_W, 8, bits resolved per pipeline stage by one CLA segment.
- NSEG, WIDTH/SEG_W (derived, localparam), number of pipeline stages; this is also the latency.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = a+b+cin, 1 = a-b-cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  add: carry-out; sub: borrow-out (1 = a < b+cin unsigned)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync-release usage):
  - All stage valid flags clear; out_valid=0; sum=0; cout=0; ovf=0; every data register cleared.
  - in_ready is 1 out of reset.
- Operand conditioning at the input, combinational:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~cin : cin.
  - The sub flag travels with the beat.
- Stage k (k = 0..NSEG-1) resolves bits [k*SEG_W +: SEG_W]:
  - p = a^b_eff and g = a&b_eff for the segment.
  - Ripple-free lookahead carries inside the segment, seeded by the carry registered from stage k-1 (stage 0 uses c_eff).
  - Segment sum = p ^ {carries[SEG_W-2:0], seed}.
- Each stage registers the following; upper operand slices are delayed alongside:
  - the completed low sum bits
  - the remaining upper operand slices
  - the segment carry-out
  - the carry into the MSB (final stage only)
  - sub
- Output registers (held in stage NSEG-1):
  - cout = raw carry-out ^ sub.
  - ovf = carry into MSB ^ raw carry-out.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+NSEG-1, i.e. NSEG register stages. Throughput is 1 beat/cycle when out_ready=1.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Stage k advances when it is empty or stage k+1 advances; the last stage advances when it is empty or out_ready=1.
  - in_ready = stage 0 advances. This is a combinational ready chain with no register slice.
  - Bubbles collapse: an empty stage accepts even while downstream stalls.
- Stall: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold stable. No beat is lost or duplicated.
- Simultaneous in- and out-transfer on a full pipe is legal and keeps it full at 1 beat/cycle.
- Inputs a/b/cin/sub are sampled only on an input transfer; values on non-transfer cycles are don't-care.
- in_valid may not be retracted by upstream once asserted until transfer; the block does not depend on this.
- Reset mid-operation: all in-flight beats are discarded immediately. Outputs go to their reset values asynchronously.
- NSEG=1 is legal: single register stage, latency 1.

Test Plan:
- WIDTH=16, SEG_W=4; a=16'hFFFF, b=16'h0001, cin=0, sub=0, out_ready=1 -> 4 edges later sum=16'h0000, cout=1, ovf=0 (full-width carry propagates across all segments).
- a=16'h7FFF, b=16'h0001, add -> sum=16'h8000, cout=0, ovf=1. Then a=16'h0003, b=16'h0005, sub=1, cin=0 -> sum=16'hFFFE, cout=1 (borrow), ovf=0.
- Stream 100 random beats back-to-back with out_ready=1 -> in_ready stays 1, one result per cycle in order, each equal to the reference model, latency exactly 4.
- Fill the pipe, then out_ready=0 for 6 cycles while in_valid=1 -> in_ready drops once 4 beats are held, output holds stable. Release -> beats drain in order with no loss or duplication.
- Insert a bubble (in_valid=0 for 1 cycle) while out_ready=0 -> the bubble collapses; in_ready stays 1 until all 4 stages are valid.
- Assert rst_n=0 for 1 cycle with 3 beats in flight -> out_valid=0 and sum=0 immediately. After release no stale beat emerges; the next beat has latency 4.

Source files
------------

// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor. One SEG_W-bit CLA segment per stage,
// with a combinational valid/ready chain so that empty stages absorb bubbles.
module adder_cla_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = WIDTH / SEG_W;

  logic [NSEG-1:0]  vld;
  logic [NSEG-1:0]  adv;
  logic [NSEG-1:0]  ld_v;

  logic [WIDTH-1:0] r_sum [NSEG];
  logic [WIDTH-1:0] r_a   [NSEG];
  logic [WIDTH-1:0] r_b   [NSEG];
  logic             r_c   [NSEG];
  logic             r_sub [NSEG];
  logic             r_cm;

  logic [WIDTH-1:0] src_a   [NSEG];
  logic [WIDTH-1:0] src_b   [NSEG];
  logic             src_sub [NSEG];
  logic [WIDTH-1:0] nx_sum  [NSEG];
  logic             nx_c    [NSEG];
  logic             nx_cm;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv = '0;
    adv[NSEG-1] = ~vld[NSEG-1] | out_ready;
    for (int unsigned i = 1; i < NSEG; i++) begin
      adv[NSEG-1-i] = ~vld[NSEG-1-i] | adv[NSEG-i];
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [WIDTH-1:0] prev_sum;
    logic [WIDTH-1:0] merged;
    logic [SEG_W-1:0] sa;
    logic [SEG_W-1:0] sb;
    logic             seed;
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W:0]   c;

    if (k == 0) begin : g_first
      assign src_a[k]   = a;
      assign src_b[k]   = sub ? ~b : b;
      assign src_sub[k] = sub;
      assign seed       = sub ? ~cin : cin;
      assign prev_sum   = '0;
      assign ld_v[k]    = in_valid;
    end else begin : g_next
      assign src_a[k]   = r_a[k-1];
      assign src_b[k]   = r_b[k-1];
      assign src_sub[k] = r_sub[k-1];
      assign seed       = r_c[k-1];
      assign prev_sum   = r_sum[k-1];
      assign ld_v[k]    = vld[k-1];
    end

    assign sa = src_a[k][k*SEG_W +: SEG_W];
    assign sb = src_b[k][k*SEG_W +: SEG_W];
    assign p  = sa ^ sb;
    assign g  = sa & sb;

    // Each carry is a flat sum of generate/propagate products, not a ripple.
    always_comb begin
      logic pp;
      pp   = 1'b0;
      c    = '0;
      c[0] = seed;
      for (int unsigned i = 0; i < SEG_W; i++) begin
        c[i+1] = g[i];
        pp     = p[i];
        for (int unsigned jj = 0; jj < i; jj++) begin
          c[i+1] = c[i+1] | (pp & g[i-1-jj]);
          pp     = pp & p[i-1-jj];
        end
        c[i+1] = c[i+1] | (pp & seed);
      end
    end

    always_comb begin
      merged = prev_sum;
      merged[k*SEG_W +: SEG_W] = p ^ c[SEG_W-1:0];
    end

    assign nx_sum[k] = merged;
    assign nx_c[k]   = c[SEG_W];

    if (k == NSEG - 1) begin : g_last
      assign nx_cm = c[SEG_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= '0;
      r_cm <= 1'b0;
      for (int unsigned i = 0; i < NSEG; i++) begin
        r_sum[i] <= '0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_c[i]   <= 1'b0;
        r_sub[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NSEG; i++) begin
        if (adv[i]) begin
          vld[i] <= ld_v[i];
          if (ld_v[i]) begin
            r_sum[i] <= nx_sum[i];
            r_a[i]   <= src_a[i];
            r_b[i]   <= src_b[i];
            r_c[i]   <= nx_c[i];
            r_sub[i] <= src_sub[i];
          end
        end
      end
      if (adv[NSEG-1] && ld_v[NSEG-1]) begin
        r_cm <= nx_cm;
      end
    end
  end

  assign out_valid = vld[NSEG-1];
  assign sum       = r_sum[NSEG-1];
  assign cout      = r_c[NSEG-1] ^ r_sub[NSEG-1];
  assign ovf       = r_cm ^ r_c[NSEG-1];

endmodule
